// File: rtl/conf_dma_sequencer.sv
// conf_dma_sequencer: splits one config-block transfer into fixed-size AXI read and write
// burst commands, and keeps CONFIG_READY low until every write burst has been acknowledged.
module conf_dma_sequencer #(
    parameter int unsigned BEAT_BYTES         = 8,
    parameter int unsigned BURST_BEATS        = 16,
    parameter int unsigned MAX_WR_OUTSTANDING = 8
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        CONFIG_VALID,
    output logic        CONFIG_READY,
    input  logic [31:0] CONFIG_CMD,
    input  logic [31:0] CONFIG_SRC,
    input  logic [31:0] CONFIG_DEST,
    input  logic [31:0] CONFIG_LEN,
    output logic        RD_CMD_VALID,
    input  logic        RD_CMD_READY,
    output logic [31:0] RD_CMD_ADDR,
    output logic [7:0]  RD_CMD_LEN,
    output logic        WR_CMD_VALID,
    input  logic        WR_CMD_READY,
    output logic [31:0] WR_CMD_ADDR,
    output logic [7:0]  WR_CMD_LEN,
    input  logic        WR_DONE,
    output logic        DONE,
    output logic        BUSY,
    output logic        ERR
);
    localparam int unsigned   OFS       = $clog2(BEAT_BYTES);
    localparam int unsigned   OW        = $clog2(MAX_WR_OUTSTANDING + 1);
    localparam logic [31:0]   LOW_MASK  = 32'(BEAT_BYTES - 1);
    localparam logic [31:0]   BURST_MAX = 32'(BURST_BEATS);
    localparam logic [OW-1:0] OUT_MAX   = OW'(MAX_WR_OUTSTANDING);
    localparam logic [OW-1:0] OUT_ONE   = OW'(1);
    localparam logic [OW-1:0] OUT_ZERO  = OW'(0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_rd_addr;
    logic [31:0]   r_wr_addr;
    logic [31:0]   r_rd_rem;
    logic [31:0]   r_wr_rem;
    logic [OW-1:0] r_wr_out;
    logic          r_err;

    logic          w_accept;
    logic          w_go_issue;
    logic          w_misalign;
    logic [31:0]   w_len_beats;
    logic [31:0]   w_rd_beats;
    logic [31:0]   w_wr_beats;
    logic          w_rd_fire;
    logic          w_wr_fire;
    logic          w_done_ok;
    logic          w_spurious;
    logic          w_unused_cmd;

    assign w_unused_cmd = ^CONFIG_CMD[31:1];
    assign w_accept     = (r_state == S_IDLE) && CONFIG_VALID;
    assign w_len_beats  = CONFIG_LEN >> OFS;
    assign w_go_issue   = CONFIG_CMD[0] && (w_len_beats != 32'd0);
    assign w_misalign   = ((CONFIG_SRC & LOW_MASK) != 32'd0) ||
                          ((CONFIG_DEST & LOW_MASK) != 32'd0) ||
                          ((CONFIG_LEN & LOW_MASK) != 32'd0);

    assign w_rd_beats = (r_rd_rem > BURST_MAX) ? BURST_MAX : r_rd_rem;
    assign w_wr_beats = (r_wr_rem > BURST_MAX) ? BURST_MAX : r_wr_rem;

    // VALIDs only depend on registers, so ADDR/LEN cannot move until the handshake completes.
    assign RD_CMD_VALID = (r_state == S_ISSUE) && (r_rd_rem != 32'd0);
    assign WR_CMD_VALID = (r_state == S_ISSUE) && (r_wr_rem != 32'd0) && (r_wr_out < OUT_MAX);
    assign RD_CMD_ADDR  = r_rd_addr;
    assign WR_CMD_ADDR  = r_wr_addr;
    assign RD_CMD_LEN   = w_rd_beats[7:0] - 8'd1;
    assign WR_CMD_LEN   = w_wr_beats[7:0] - 8'd1;

    assign w_rd_fire  = RD_CMD_VALID && RD_CMD_READY;
    assign w_wr_fire  = WR_CMD_VALID && WR_CMD_READY;
    assign w_done_ok  = WR_DONE && (r_wr_out != OUT_ZERO);
    assign w_spurious = WR_DONE && (r_wr_out == OUT_ZERO);

    assign CONFIG_READY = (r_state == S_IDLE);
    assign BUSY         = (r_state != S_IDLE);
    assign DONE         = (r_state == S_FIN);
    assign ERR          = r_err;

    // State register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; ISSUE exit is judged on the registered remaining counts.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (CONFIG_VALID) begin
                    w_state_nxt = w_go_issue ? S_ISSUE : S_FIN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                if ((r_rd_rem == 32'd0) && (r_wr_rem == 32'd0)) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (r_wr_out == OUT_ZERO) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address/remaining counters per path, outstanding write count and sticky error.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rd_addr <= 32'd0;
            r_wr_addr <= 32'd0;
            r_rd_rem  <= 32'd0;
            r_wr_rem  <= 32'd0;
            r_wr_out  <= OUT_ZERO;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rd_addr <= CONFIG_SRC & ~LOW_MASK;
                r_wr_addr <= CONFIG_DEST & ~LOW_MASK;
                r_rd_rem  <= w_go_issue ? w_len_beats : 32'd0;
                r_wr_rem  <= w_go_issue ? w_len_beats : 32'd0;
            end else begin
                if (w_rd_fire) begin
                    r_rd_addr <= r_rd_addr + (w_rd_beats << OFS);
                    r_rd_rem  <= r_rd_rem - w_rd_beats;
                end
                if (w_wr_fire) begin
                    r_wr_addr <= r_wr_addr + (w_wr_beats << OFS);
                    r_wr_rem  <= r_wr_rem - w_wr_beats;
                end
            end

            case ({w_wr_fire, w_done_ok})
                2'b10:   r_wr_out <= r_wr_out + OUT_ONE;
                2'b01:   r_wr_out <= r_wr_out - OUT_ONE;
                default: r_wr_out <= r_wr_out;
            endcase

            if (w_accept) begin
                r_err <= w_misalign | w_spurious;
            end else if (w_spurious) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end
endmodule

// File: tb/tb_conf_dma_sequencer.sv
// Scoreboard bench for conf_dma_sequencer: expected bursts/retirements are queued at issue
// time and a negedge monitor pops and compares them as the DUT presents handshakes.
module tb_conf_dma_sequencer;
    localparam int BB    = 8;
    localparam int BURST = 16;
    localparam int MAXO  = 8;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        CONFIG_VALID;
    logic        CONFIG_READY;
    logic [31:0] CONFIG_CMD, CONFIG_SRC, CONFIG_DEST, CONFIG_LEN;
    logic        RD_CMD_VALID, RD_CMD_READY;
    logic [31:0] RD_CMD_ADDR;
    logic [7:0]  RD_CMD_LEN;
    logic        WR_CMD_VALID, WR_CMD_READY;
    logic [31:0] WR_CMD_ADDR;
    logic [7:0]  WR_CMD_LEN;
    logic        WR_DONE;
    logic        DONE, BUSY, ERR;

    always #5 ACLK = ~ACLK;

    conf_dma_sequencer #(.BEAT_BYTES(BB), .BURST_BEATS(BURST), .MAX_WR_OUTSTANDING(MAXO)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .CONFIG_VALID(CONFIG_VALID), .CONFIG_READY(CONFIG_READY),
        .CONFIG_CMD(CONFIG_CMD), .CONFIG_SRC(CONFIG_SRC),
        .CONFIG_DEST(CONFIG_DEST), .CONFIG_LEN(CONFIG_LEN),
        .RD_CMD_VALID(RD_CMD_VALID), .RD_CMD_READY(RD_CMD_READY),
        .RD_CMD_ADDR(RD_CMD_ADDR), .RD_CMD_LEN(RD_CMD_LEN),
        .WR_CMD_VALID(WR_CMD_VALID), .WR_CMD_READY(WR_CMD_READY),
        .WR_CMD_ADDR(WR_CMD_ADDR), .WR_CMD_LEN(WR_CMD_LEN),
        .WR_DONE(WR_DONE), .DONE(DONE), .BUSY(BUSY), .ERR(ERR)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } burst_t;

    burst_t rd_q[$];
    burst_t wr_q[$];
    bit     err_q[$];

    int checks   = 0;
    int failures = 0;

    int rd_mode    = 0;  // 0 ready high, 1 random, 2 ready low
    int wr_mode    = 0;
    bit auto_done  = 1'b1;
    int man_req    = 0;
    int man_served = 0;

    int mon_out   = 0;
    int wr_hs_cnt = 0;
    int done_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Reference model: byte-level split of a transfer into bursts.
    task automatic expect_cmd(input logic [31:0] cmd, input logic [31:0] src,
                              input logic [31:0] dst, input logic [31:0] len);
        int unsigned beats;
        int unsigned rem;
        int unsigned n;
        logic [31:0] a;
        logic [31:0] b;
        burst_t bt;
        beats = len / BB;
        a = src - (src % BB);
        b = dst - (dst % BB);
        if (cmd[0] && beats > 0) begin
            rem = beats;
            while (rem > 0) begin
                n = (rem < BURST) ? rem : BURST;
                bt.len  = 8'(n - 1);
                bt.addr = a;
                rd_q.push_back(bt);
                bt.addr = b;
                wr_q.push_back(bt);
                a = a + n * BB;
                b = b + n * BB;
                rem = rem - n;
            end
        end
        err_q.push_back((src % BB != 0) || (dst % BB != 0) || (len % BB != 0));
    endtask

    task automatic drive_cmd(input logic [31:0] cmd, input logic [31:0] src,
                             input logic [31:0] dst, input logic [31:0] len);
        int n = 0;
        while (!CONFIG_READY && n < 5000) begin
            @(posedge ACLK); #1;
            n++;
        end
        if (!CONFIG_READY) fail_now("config_ready_timeout");
        CONFIG_CMD   = cmd;
        CONFIG_SRC   = src;
        CONFIG_DEST  = dst;
        CONFIG_LEN   = len;
        CONFIG_VALID = 1'b1;
        @(posedge ACLK); #1;
        CONFIG_VALID = 1'b0;
    endtask

    task automatic send_cmd(input logic [31:0] cmd, input logic [31:0] src,
                            input logic [31:0] dst, input logic [31:0] len);
        expect_cmd(cmd, src, dst, len);
        drive_cmd(cmd, src, dst, len);
    endtask

    task automatic wait_done(input int base, input string name);
        int n = 0;
        while (done_cnt == base && n < 5000) begin
            @(posedge ACLK); #1;
            n++;
        end
        if (done_cnt == base) fail_now({name, "_done_timeout"});
    endtask

    task automatic push_test1_table();
        burst_t bt;
        for (int i = 0; i < 4; i++) begin
            bt.len  = (i == 3) ? 8'd1 : 8'd15;
            bt.addr = 32'h1000 + 32'(i) * 32'h80;
            rd_q.push_back(bt);
            bt.addr = 32'h8000 + 32'(i) * 32'h80;
            wr_q.push_back(bt);
        end
        err_q.push_back(1'b0);
    endtask

    // Responder: READY patterns and WR_DONE pulses (manual requests first, then automatic).
    initial begin
        RD_CMD_READY = 1'b0;
        WR_CMD_READY = 1'b0;
        WR_DONE      = 1'b0;
        forever begin
            @(posedge ACLK); #1;
            if (rd_mode == 0)      RD_CMD_READY = 1'b1;
            else if (rd_mode == 1) RD_CMD_READY = 1'($urandom_range(0, 1));
            else                   RD_CMD_READY = 1'b0;
            if (wr_mode == 0)      WR_CMD_READY = 1'b1;
            else if (wr_mode == 1) WR_CMD_READY = 1'($urandom_range(0, 1));
            else                   WR_CMD_READY = 1'b0;
            if (man_req > man_served) begin
                WR_DONE = 1'b1;
                man_served++;
            end else if (auto_done && mon_out > 0 && $urandom_range(0, 2) == 0) begin
                WR_DONE = 1'b1;
            end else begin
                WR_DONE = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on handshakes/DONE and checks hold and gating rules.
    initial begin
        bit     prev_rd_wait = 1'b0;
        bit     prev_wr_wait = 1'b0;
        bit     prev_done    = 1'b0;
        burst_t prev_rd, prev_wr, exp_b;
        bit     wr_fire;
        int     mo;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                mon_out      = 0;
                prev_rd_wait = 1'b0;
                prev_wr_wait = 1'b0;
                prev_done    = 1'b0;
            end else begin
                mo = mon_out;
                if (prev_rd_wait) begin
                    check("rd_hold_valid", RD_CMD_VALID, 1);
                    check("rd_hold_addr", RD_CMD_ADDR, prev_rd.addr);
                    check("rd_hold_len", RD_CMD_LEN, prev_rd.len);
                end
                if (prev_wr_wait) begin
                    check("wr_hold_valid", WR_CMD_VALID, 1);
                    check("wr_hold_addr", WR_CMD_ADDR, prev_wr.addr);
                    check("wr_hold_len", WR_CMD_LEN, prev_wr.len);
                end
                if (prev_done) begin
                    check("ready_after_done", CONFIG_READY, 1);
                    check("idle_after_done", BUSY, 0);
                end
                if (mo >= MAXO) check("wr_outstanding_gate", WR_CMD_VALID, 0);
                if (RD_CMD_VALID) check("rd_valid_expected", rd_q.size() > 0, 1);
                if (WR_CMD_VALID) check("wr_valid_expected", wr_q.size() > 0, 1);
                if (RD_CMD_VALID && RD_CMD_READY && rd_q.size() > 0) begin
                    exp_b = rd_q.pop_front();
                    check("rd_addr", RD_CMD_ADDR, exp_b.addr);
                    check("rd_len", RD_CMD_LEN, exp_b.len);
                end
                wr_fire = WR_CMD_VALID && WR_CMD_READY;
                if (wr_fire) begin
                    wr_hs_cnt++;
                    if (wr_q.size() > 0) begin
                        exp_b = wr_q.pop_front();
                        check("wr_addr", WR_CMD_ADDR, exp_b.addr);
                        check("wr_len", WR_CMD_LEN, exp_b.len);
                    end
                end
                if (DONE) begin
                    done_cnt++;
                    if (err_q.size() == 0) fail_now("done_unexpected");
                    else check("done_err", ERR, err_q.pop_front());
                    check("done_rd_drained", rd_q.size(), 0);
                    check("done_wr_drained", wr_q.size(), 0);
                    check("done_outstanding", mo, 0);
                end
                prev_done    = DONE;
                prev_rd_wait = RD_CMD_VALID && !RD_CMD_READY;
                prev_wr_wait = WR_CMD_VALID && !WR_CMD_READY;
                prev_rd.addr = RD_CMD_ADDR;
                prev_rd.len  = RD_CMD_LEN;
                prev_wr.addr = WR_CMD_ADDR;
                prev_wr.len  = WR_CMD_LEN;
                mon_out = mo + (wr_fire ? 1 : 0) - ((WR_DONE && mo > 0) ? 1 : 0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int hs0;
        logic [31:0] src, dst, len, cmd;

        ARESET       = 1'b1;
        CONFIG_VALID = 1'b0;
        CONFIG_CMD   = 32'd0;
        CONFIG_SRC   = 32'd0;
        CONFIG_DEST  = 32'd0;
        CONFIG_LEN   = 32'd0;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_ready", CONFIG_READY, 1);
        check("rst_busy", BUSY, 0);
        check("rst_rd_valid", RD_CMD_VALID, 0);
        check("rst_wr_valid", WR_CMD_VALID, 0);
        check("rst_done", DONE, 0);
        check("rst_err", ERR, 0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;

        // Directed 50-beat transfer against a literal burst table.
        push_test1_table();
        base = done_cnt;
        drive_cmd(32'd1, 32'h1000, 32'h8000, 32'd400);
        wait_done(base, "t1");

        // No-op transfers: CMD=0, and a sub-beat length.
        base = done_cnt;
        send_cmd(32'd0, 32'h1000, 32'h8000, 32'd400);
        check("cmd0_done_latency", DONE, 1);
        wait_done(base, "cmd0");
        base = done_cnt;
        send_cmd(32'd1, 32'h1000, 32'h8000, 32'd4);
        check("len4_done_latency", DONE, 1);
        check("len4_err", ERR, 1);
        wait_done(base, "len4");

        // Outstanding limit and WR_DONE coincident with a write handshake (12 bursts).
        auto_done = 1'b0;
        hs0  = wr_hs_cnt;
        base = done_cnt;
        send_cmd(32'd1, 32'h2000, 32'h4000, 32'd1536);
        repeat (60) @(posedge ACLK);
        #1;
        check("limit_hs", wr_hs_cnt - hs0, 8);
        check("limit_valid_low", WR_CMD_VALID, 0);
        man_req = man_req + 1;
        repeat (10) @(posedge ACLK);
        #1;
        check("limit_one_more", wr_hs_cnt - hs0, 9);
        man_req = man_req + 2;
        repeat (10) @(posedge ACLK);
        #1;
        check("coincident_done_hs", wr_hs_cnt - hs0, 11);
        check("coincident_valid_low", WR_CMD_VALID, 0);
        auto_done = 1'b1;
        wait_done(base, "limit");

        // Same directed transfer with randomly toggled READYs.
        rd_mode = 1;
        wr_mode = 1;
        push_test1_table();
        base = done_cnt;
        drive_cmd(32'd1, 32'h1000, 32'h8000, 32'd400);
        wait_done(base, "t1_rand");
        rd_mode = 0;
        wr_mode = 0;

        // Spurious WR_DONE in IDLE sets ERR; the next accepted command clears it.
        auto_done = 1'b0;
        man_req = man_req + 1;
        repeat (3) @(posedge ACLK);
        #1;
        check("spurious_err", ERR, 1);
        auto_done = 1'b1;
        base = done_cnt;
        send_cmd(32'd1, 32'h100, 32'h200, 32'd64);
        check("err_cleared_on_accept", ERR, 0);
        wait_done(base, "post_spurious");

        // Asynchronous reset in the middle of ISSUE.
        rd_mode = 2;
        wr_mode = 2;
        send_cmd(32'd1, 32'h3000, 32'h5000, 32'd800);
        repeat (3) @(posedge ACLK);
        #1;
        check("pre_rst_rd_valid", RD_CMD_VALID, 1);
        check("pre_rst_busy", BUSY, 1);
        #2;
        ARESET = 1'b1;
        #1;
        check("async_rst_rd_valid", RD_CMD_VALID, 0);
        check("async_rst_wr_valid", WR_CMD_VALID, 0);
        check("async_rst_busy", BUSY, 0);
        check("async_rst_ready", CONFIG_READY, 1);
        rd_q.delete();
        wr_q.delete();
        err_q.delete();
        repeat (2) @(posedge ACLK);
        #1;
        ARESET  = 1'b0;
        rd_mode = 0;
        wr_mode = 0;
        check("post_rst_ready", CONFIG_READY, 1);
        check("post_rst_err", ERR, 0);
        base = done_cnt;
        send_cmd(32'd1, 32'h6000, 32'h7000, 32'd264);
        wait_done(base, "post_rst");

        // Randomized transfers against the model.
        for (int i = 0; i < 25; i++) begin
            src = $urandom;
            dst = $urandom;
            len = 32'($urandom_range(0, 3000));
            if ($urandom_range(0, 1) == 0) src = src & 32'hFFFF_FFF8;
            if ($urandom_range(0, 1) == 0) dst = dst & 32'hFFFF_FFF8;
            if ($urandom_range(0, 9) < 7) len = len & 32'hFFFF_FFF8;
            cmd = $urandom & 32'hFFFF_FFFE;
            if ($urandom_range(0, 9) != 0) cmd = cmd | 32'd1;
            rd_mode = $urandom_range(0, 1);
            wr_mode = $urandom_range(0, 1);
            base = done_cnt;
            send_cmd(cmd, src, dst, len);
            wait_done(base, "random");
        end

        repeat (5) @(posedge ACLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
